// File: rtl/wb_pkg.sv
// Shared sizing for the write-back register file and its
// per-register pending-write scoreboard.
package wb_pkg;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int CW   = 2;
   localparam int NREG = 32;

   localparam logic [CW-1:0] CNT_MAX = 2'd3;

   typedef logic [DW-1:0] word_t;
   typedef logic [AW-1:0] addr_t;
   typedef logic [CW-1:0] cnt_t;

   typedef enum logic [1:0] {
      SB_HOLD = 2'b00,
      SB_DEC  = 2'b01,
      SB_INC  = 2'b10,
      SB_BOTH = 2'b11
   } sb_op_e;
endpackage

// File: rtl/wb_regfile_sb_cnt.sv
// Saturating pending-write counter for one register; flags
// overflow on inc at max and underflow on dec at zero.
module sb_cnt
   import wb_pkg::*;
#(
   parameter int CW = wb_pkg::CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [CW-1:0] o_cnt,
   output logic          o_ovf,
   output logic          o_unf
);

   localparam logic [CW-1:0] W_MAX = '1;

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_nxt;
   sb_op_e        w_op;

   always_comb begin
      w_op  = sb_op_e'({i_inc, i_dec});
      w_nxt = r_cnt;
      o_ovf = 1'b0;
      o_unf = 1'b0;
      unique case (w_op)
         SB_INC: begin
            if (r_cnt == W_MAX) o_ovf = 1'b1;
            else                w_nxt = r_cnt + 1'b1;
         end
         SB_DEC: begin
            if (r_cnt == '0) o_unf = 1'b1;
            else             w_nxt = r_cnt - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else     r_cnt <= w_nxt;
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/wb_regfile.sv
// Register file with same-cycle write bypass and a per-register
// pending-write scoreboard that stalls issue on RAW hazards.
module wb_regfile
   import wb_pkg::*;
#(
   parameter int DW = wb_pkg::DW,
   parameter int AW = wb_pkg::AW,
   parameter int CW = wb_pkg::CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_write,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   input  logic          rs_use,
   input  logic          rt_use,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_dst,
   input  logic          iss_wr,
   output logic          stall,
   output logic [1:0]    sb_err
);

   localparam int NR = 1 << AW;

   logic [DW-1:0] r_regs [NR];
   logic [CW-1:0] w_pend [NR];
   logic [NR-1:0] w_inc;
   logic [NR-1:0] w_dec;
   logic [NR-1:0] w_ovf;
   logic [NR-1:0] w_unf;
   logic [1:0]    r_err;
   logic          w_ret;
   logic          w_acc;
   logic          w_blk_rs;
   logic          w_blk_rt;

   // r0 never has an outstanding writer
   assign w_pend[0] = '0;
   assign w_inc[0]  = 1'b0;
   assign w_dec[0]  = 1'b0;
   assign w_ovf[0]  = 1'b0;
   assign w_unf[0]  = 1'b0;

   for (genvar n = 1; n < NR; n++) begin : g_cnt
      assign w_inc[n] = w_acc & (iss_dst == AW'(n));
      assign w_dec[n] = w_ret & (wb_addr == AW'(n));

      sb_cnt #(.CW(CW)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .i_inc (w_inc[n]),
         .i_dec (w_dec[n]),
         .o_cnt (w_pend[n]),
         .o_ovf (w_ovf[n]),
         .o_unf (w_unf[n])
      );
   end

   // A source whose last pending writer retires this cycle is
   // satisfied by the bypass, so it does not block.
   always_comb begin
      w_ret = wb_write & (wb_addr != '0);

      w_blk_rs = rs_use
               & (rs_addr != '0)
               & (w_pend[rs_addr] != '0)
               & ~(w_ret
                   & (wb_addr == rs_addr)
                   & (w_pend[rs_addr] == CW'(1)));

      w_blk_rt = rt_use
               & (rt_addr != '0)
               & (w_pend[rt_addr] != '0)
               & ~(w_ret
                   & (wb_addr == rt_addr)
                   & (w_pend[rt_addr] == CW'(1)));

      stall = ~rst & iss_valid & (w_blk_rs | w_blk_rt);

      w_acc = iss_valid & ~stall & iss_wr & (iss_dst != '0);
   end

   always_comb begin
      rs_data = '0;
      if (!rst && rs_addr != '0) begin
         if (w_ret && wb_addr == rs_addr) rs_data = wb_data;
         else                             rs_data = r_regs[rs_addr];
      end
   end

   always_comb begin
      rt_data = '0;
      if (!rst && rt_addr != '0) begin
         if (w_ret && wb_addr == rt_addr) rt_data = wb_data;
         else                             rt_data = r_regs[rt_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) r_regs[i] <= '0;
      end else if (w_ret) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err <= '0;
      else     r_err <= r_err | {|w_unf, |w_ovf};
   end

   assign sb_err = r_err;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios then random
// traffic, checked against a behavioural register/scoreboard model.
module tb_wb_regfile;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_write = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic [4:0]  rs_addr = '0;
   logic [4:0]  rt_addr = '0;
   logic        rs_use = 1'b0;
   logic        rt_use = 1'b0;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_dst = '0;
   logic        iss_wr = 1'b0;
   logic        stall;
   logic [1:0]  sb_err;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .wb_write  (wb_write),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_use    (rs_use),
      .rt_use    (rt_use),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .iss_wr    (iss_wr),
      .stall     (stall),
      .sb_err    (sb_err)
   );

   typedef struct {
      string       name;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        st;
      logic [1:0]  err;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [31:0] m_reg [32];
   int          m_pend [32];
   logic [1:0]  m_err;

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s.%s: got %h want %h", nm, fld, act, exp);
   endtask

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (wb_write && wb_addr == a) return wb_data;
      return m_reg[a];
   endfunction

   function automatic bit m_blk(input bit u, input logic [4:0] a);
      if (!u || a == 0 || m_pend[a] == 0) return 1'b0;
      if (wb_write && wb_addr == a && m_pend[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = '0;
         m_pend[i] = 0;
      end
      m_err = 2'b00;
   endtask

   // rmode: 0 = run, 1 = hold reset, 2 = assert reset mid-cycle
   task automatic cyc(input logic wbw, input logic [4:0] wba,
                      input logic [31:0] wbd,
                      input logic [4:0] rsa, input logic rsu,
                      input logic [4:0] rta, input logic rtu,
                      input logic iv, input logic [4:0] dst,
                      input logic iw, input string nm,
                      input int rmode);
      exp_t e;
      bit   st, ret, acc, same;
      @(negedge clk);
      rst       = (rmode == 1);
      wb_write  = wbw;
      wb_addr   = wba;
      wb_data   = wbd;
      rs_addr   = rsa;
      rs_use    = rsu;
      rt_addr   = rta;
      rt_use    = rtu;
      iss_valid = iv;
      iss_dst   = dst;
      iss_wr    = iw;
      if (rmode == 2) begin
         #1;
         rst = 1'b1;
      end
      if (rst) begin
         m_clear();
         e = '{nm, 32'h0, 32'h0, 1'b0, 2'b00};
      end else begin
         st = iv && (m_blk(rsu, rsa) || m_blk(rtu, rta));
         e  = '{nm, m_rd(rsa), m_rd(rta), st, m_err};
         ret  = wbw && wba != 0;
         acc  = iv && !st && iw && dst != 0;
         same = ret && acc && wba == dst;
         if (ret) m_reg[wba] = wbd;
         if (acc && !same) begin
            if (m_pend[dst] == 3) m_err[0] = 1'b1;
            else                  m_pend[dst]++;
         end
         if (ret && !same) begin
            if (m_pend[wba] == 0) m_err[1] = 1'b1;
            else                  m_pend[wba]--;
         end
      end
      q.push_back(e);
   endtask

   task automatic idle(input string nm);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "rs_data", rs_data, e.rs);
            chk(e.name, "rt_data", rt_data, e.rt);
            chk(e.name, "stall", {31'h0, stall}, {31'h0, e.st});
            chk(e.name, "sb_err", {30'h0, sb_err}, {30'h0, e.err});
         end
      end
   end

   initial begin : stim
      m_clear();
      cyc(1, 5, 32'hFFFF_FFFF, 5, 1, 5, 1, 1, 5, 1, "rst_hold", 1);
      cyc(1, 6, 32'h1111_2222, 6, 1, 6, 1, 1, 6, 1, "rst_hold2", 1);
      cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, "wr_r5", 0);
      cyc(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, "rd_r5", 0);
      cyc(1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, "wr_r0", 0);
      cyc(0, 0, 0, 0, 1, 5, 1, 0, 0, 0, "rd_r0", 0);
      cyc(1, 7, 32'hA5A5_A5A5, 5, 0, 7, 1, 0, 0, 0, "byp_r7", 0);
      cyc(0, 0, 0, 7, 0, 7, 0, 0, 0, 0, "rd_r7", 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, "iss_r3", 0);
      cyc(0, 0, 0, 3, 1, 0, 0, 1, 0, 0, "haz_r3", 0);
      cyc(1, 3, 32'h0333_0333, 3, 1, 0, 0, 1, 0, 0, "ret_r3", 0);
      cyc(0, 0, 0, 3, 1, 3, 1, 1, 0, 0, "clr_r3", 0);
      for (int i = 0; i < 4; i++)
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, "sat_iss", 0);
      cyc(0, 0, 0, 0, 0, 9, 1, 1, 0, 0, "sat_stall", 0);
      for (int i = 0; i < 3; i++)
         cyc(1, 9, $urandom, 0, 0, 9, 0, 0, 0, 0, "sat_ret", 0);
      cyc(0, 0, 0, 9, 1, 9, 1, 1, 0, 0, "sat_done", 0);
      cyc(1, 4, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, "unf_r4", 0);
      cyc(0, 0, 0, 4, 1, 9, 1, 0, 0, 0, "rd_r4", 0);
      cyc(1, 6, 32'h6666_6666, 5, 1, 4, 1, 1, 5, 1, "mid_rst", 2);
      cyc(0, 0, 0, 5, 1, 4, 1, 0, 0, 0, "rst_hold3", 1);
      cyc(0, 0, 0, 5, 1, 4, 1, 0, 0, 0, "post_rst", 0);
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 1),
             5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom_range(0, 1),
             5'($urandom_range(0, 7)), $urandom_range(0, 1),
             $urandom_range(0, 1), 5'($urandom_range(0, 7)),
             $urandom_range(0, 1), "rand",
             ($urandom_range(0, 59) == 0) ? 2 : 0);
      end
      idle("drain");
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      #10;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
